// File: rtl/pingpong_ctrl.sv
// Two-bank ping-pong buffer controller: the writer fills one bank while the reader drains the other.
// Read data is valid 1 cycle after its strobe; in_ready drops while the target bank is still full, and reads stall on out_ready.
module pingpong_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          inclk0,
    input  logic          areset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          ram_a_we,
    output logic          ram_b_we,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic          ram_a_re,
    output logic          ram_b_re,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_a_q,
    input  logic [DW-1:0] ram_b_q,
    output logic [1:0]    bank_full
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, READ} rd_state_t;

    rd_state_t     state_q;
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          rd_bank_q;
    logic [AW-1:0] rd_cnt_q;
    logic          out_valid_q, out_last_q, out_sel_q;

    logic          wr_acc, rd_acc, wr_last, rd_last;
    logic [1:0]    full_set, full_clr;

    always_comb begin
        in_ready = ~bank_full_q[wr_bank_q];
        wr_acc   = in_valid & in_ready;
        wr_last  = wr_acc && (wr_cnt_q == LAST);
        rd_acc   = (state_q == READ) && out_ready;
        rd_last  = rd_acc && (rd_cnt_q == LAST);

        full_set = 2'b00;
        full_clr = 2'b00;
        if (wr_last) full_set[wr_bank_q] = 1'b1;
        if (rd_last) full_clr[rd_bank_q] = 1'b1;
        // Set and clear always target different bits, so both apply in one edge.
        bank_full_d = (bank_full_q | full_set) & ~full_clr;

        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (wr_acc) wr_cnt_d = wr_last ? '0 : wr_cnt_q + AW'(1);
        if (wr_last) wr_bank_d = ~wr_bank_q;
    end

    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            bank_full_q <= 2'b00;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            bank_full_q <= bank_full_d;
        end
    end

    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 1'b0;
        end else begin
            out_valid_q <= rd_acc;
            out_last_q  <= rd_last;
            if (rd_acc) out_sel_q <= rd_bank_q;
            case (state_q)
                IDLE: begin
                    if (bank_full_q[rd_bank_q]) begin
                        state_q  <= READ;
                        rd_cnt_q <= '0;
                    end
                end
                READ: begin
                    if (rd_acc) begin
                        if (rd_last) begin
                            rd_cnt_q  <= '0;
                            rd_bank_q <= ~rd_bank_q;
                            state_q   <= IDLE;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + AW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_a_we    = wr_acc & ~wr_bank_q;
    assign ram_b_we    = wr_acc &  wr_bank_q;
    assign ram_wr_addr = wr_cnt_q;
    assign ram_wr_data = in_data;
    assign ram_a_re    = rd_acc & ~rd_bank_q;
    assign ram_b_re    = rd_acc &  rd_bank_q;
    assign ram_rd_addr = rd_cnt_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_data    = out_sel_q ? ram_b_q : ram_a_q;
    assign bank_full   = bank_full_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl with DEPTH=4, DW=8 and a behavioural two-bank RAM.
module tb_pingpong_ctrl;

    localparam int DW = 8, DEPTH = 4, AW = 2;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_last;
    logic [DW-1:0] out_data, ram_wr_data;
    logic          ram_a_we, ram_b_we, ram_a_re, ram_b_re;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_a_q = '0, ram_b_q = '0;
    logic [1:0]    bank_full;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];
    logic [8:0]    got_q [$];
    logic [8:0]    exp_q [$];
    logic          prev_re = 1'b0;
    int            n_checks = 0, n_fail = 0;

    pingpong_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .inclk0(clk), .areset(areset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .ram_a_we(ram_a_we), .ram_b_we(ram_b_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_a_re(ram_a_re), .ram_b_re(ram_b_re), .ram_rd_addr(ram_rd_addr),
        .ram_a_q(ram_a_q), .ram_b_q(ram_b_q), .bank_full(bank_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_a_we) mem_a[ram_wr_addr] <= ram_wr_data;
        if (ram_b_we) mem_b[ram_wr_addr] <= ram_wr_data;
        if (ram_a_re) ram_a_q <= mem_a[ram_rd_addr];
        if (ram_b_re) ram_b_q <= mem_b[ram_rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got_v, exp_v, $time);
        end
    endtask

    // Collect the output stream and check strobe gating and read latency every cycle.
    always @(negedge clk) begin
        if (areset) begin
            prev_re = 1'b0;
        end else begin
            check_eq("re_gate", 32'((ram_a_re | ram_b_re) & ~out_ready), 0);
            check_eq("we_gate", 32'((ram_a_we | ram_b_we) & ~in_ready), 0);
            if (out_valid) begin
                check_eq("rd_latency", 32'(prev_re), 1);
                got_q.push_back({out_last, out_data});
            end
            prev_re = ram_a_re | ram_b_re;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        areset    = 1'b1;
        step();
        areset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push(input logic [7:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        check_eq("push_timeout", 32'(t < 50), 1);
        step();
    endtask

    task automatic wait_words(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 200) begin
            step();
            t++;
        end
        repeat (3) step();
    endtask

    task automatic cmp_stream(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check_eq("rst_full", 32'(bank_full), 0);
        check_eq("rst_ready", 32'(in_ready), 1);
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_last", 32'(out_last), 0);
        check_eq("rst_re", 32'({ram_a_re, ram_b_re}), 0);
        do_reset();

        // Fill bank A with the reader held off
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        in_valid = 1'b0;
        #1;
        check_eq("a_full", 32'(bank_full), 32'h1);
        check_eq("a_full_ready", 32'(in_ready), 1);
        step();
        check_eq("a_full_no_re", 32'({ram_a_re, ram_b_re}), 0);
        in_valid = 1'b1;
        in_data  = 8'h14;
        #1;
        check_eq("next_is_b_we", 32'({ram_a_we, ram_b_we}), 32'h1);
        check_eq("next_is_b_addr", 32'(ram_wr_addr), 0);
        in_valid = 1'b0;

        // Both banks full: a ninth word is refused
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        check_eq("both_full", 32'(bank_full), 32'h3);
        check_eq("both_full_ready", 32'(in_ready), 0);
        in_data = 8'h99;
        #1;
        check_eq("ninth_no_we", 32'({ram_a_we, ram_b_we}), 0);
        step();
        check_eq("ninth_still_full", 32'(bank_full), 32'h3);
        check_eq("ninth_no_we2", 32'({ram_a_we, ram_b_we}), 0);
        in_valid = 1'b0;

        // Drain with out_ready toggling every cycle
        got_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({1'(i % 4 == 3), 8'h20 + 8'(i)});
        begin
            int t;
            t = 0;
            while (got_q.size() < 8 && t < 100) begin
                out_ready = ~out_ready;
                step();
                t++;
            end
        end
        out_ready = 1'b0;
        repeat (3) step();
        cmp_stream("toggle");
        check_eq("toggle_empty", 32'(bank_full), 0);

        // Continuous writes with the reader always ready
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back({1'(i % 4 == 3), 8'h20 + 8'(i)});
        wait_words(8);
        cmp_stream("stream");
        check_eq("stream_empty", 32'(bank_full), 0);

        // Final write to B in the same cycle as the final read of A
        do_reset();
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = 8'h40 + 8'(i);
            #1;
            check_eq("swap_no_stall", 32'(in_ready), 1);
            if (i == 3) check_eq("swap_before", 32'(bank_full), 32'h1);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("swap_after", 32'(bank_full), 32'h2);
        check_eq("swap_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'(i == 3), 8'h30 + 8'(i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'(i == 3), 8'h40 + 8'(i)});
        wait_words(8);
        cmp_stream("swap");
        out_ready = 1'b0;

        // Reset mid-operation, then a fresh burst
        do_reset();
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h60;
        step();
        out_ready = 1'b0;
        in_data   = 8'h61;
        step();
        in_valid = 1'b0;
        check_eq("mid_words_read", got_q.size(), 1);
        check_eq("mid_full", 32'(bank_full), 32'h1);
        #2;
        areset = 1'b1;
        #1;
        check_eq("async_full", 32'(bank_full), 0);
        check_eq("async_valid", 32'(out_valid), 0);
        check_eq("async_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        check_eq("edge_full", 32'(bank_full), 0);
        check_eq("edge_valid_last", 32'({out_valid, out_last}), 0);
        check_eq("edge_strobes", 32'({ram_a_we, ram_b_we, ram_a_re, ram_b_re}), 0);
        check_eq("edge_ready", 32'(in_ready), 1);
        areset = 1'b0;
        got_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h70;
        #1;
        check_eq("fresh_a_we", 32'({ram_a_we, ram_b_we}), 32'h2);
        check_eq("fresh_addr", 32'(ram_wr_addr), 0);
        for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'(i == 3), 8'h70 + 8'(i)});
        wait_words(4);
        cmp_stream("fresh");
        check_eq("fresh_empty", 32'(bank_full), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 Parameter DW, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, words per bank; SHALL be a power of two, at least 2.
REQ-003 Parameter AW, default 4, address width; SHALL equal log2(DEPTH).
REQ-004 inclk0  input  1  single clock; all state updates on its rising edge.
REQ-005 areset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  write-side word present.
REQ-007 in_ready  output  1  controller can accept in_data this cycle.
REQ-008 in_data  input  DW  write-side word.
REQ-009 out_ready  input  1  downstream accepts a word one cycle after this cycle.
REQ-010 out_valid  output  DW-independent 1  out_data valid; registered.
REQ-011 out_data  output  DW  read word, muxed from ram_a_q or ram_b_q.
REQ-012 out_last  output  1  marks the final word of a bank; registered, qualified by out_valid.
REQ-013 ram_a_we, ram_b_we  output  1 each  bank write strobes.
REQ-014 ram_wr_addr  output  AW; ram_wr_data  output  DW  shared write address and data.
REQ-015 ram_a_re, ram_b_re  output  1 each  bank read strobes; ram_rd_addr  output  AW.
REQ-016 ram_a_q, ram_b_q  input  DW each  RAM read data, valid exactly 1 cycle after its read strobe.
REQ-017 bank_full  output  2  bit0 = bank A full, bit1 = bank B full.

Function
REQ-018 Write-side state: wr_bank (0 = A, 1 = B), wr_cnt (AW bits).
REQ-019 in_ready = ~bank_full[wr_bank], combinational.
REQ-020 Accept = in_valid & in_ready; on accept, assert the we of wr_bank combinationally, ram_wr_addr = wr_cnt, ram_wr_data = in_data.
REQ-021 Accept with wr_cnt < DEPTH-1: wr_cnt increments.
REQ-022 Accept with wr_cnt = DEPTH-1: set bank_full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
REQ-023 If the new wr_bank is still full, in_ready SHALL be low until the reader clears it; no write strobe while in_ready is low.
REQ-024 Read FSM states: IDLE, READ; read-side state: rd_bank (1 bit), rd_cnt (AW bits).
REQ-025 IDLE -> READ when bank_full[rd_bank] = 1; rd_cnt = 0 on entry.
REQ-026 In READ with out_ready = 1, assert the re of rd_bank, ram_rd_addr = rd_cnt, and increment rd_cnt.
REQ-027 In READ with out_ready = 0, assert no re; hold rd_cnt.
REQ-028 Read issued at rd_cnt = DEPTH-1: clear bank_full[rd_bank], toggle rd_bank, go to IDLE, rd_cnt wraps to 0.
REQ-029 Latency 1: out_valid, out_last and the bank select are registered from the read strobe; out_data selects ram_a_q or ram_b_q by the registered select.
REQ-030 Writer sets only bits of non-full banks; reader clears only bits of full banks, so the same bit is never set and cleared in one cycle.
REQ-031 Set of one bank_full bit and clear of the other bit in the same cycle: both take effect.
REQ-032 Final write to a bank that the reader is clearing in the same cycle: in_ready evaluates the pre-clear value; writing resumes next cycle.
REQ-033 Throughput: concurrent write of one bank and read of the other, one word per cycle each, with no bubbles when both sides are continuous.
REQ-034 Bank order is strictly alternating A, B, A, ...; each bank's words are read out in address order 0..DEPTH-1.

Reset
REQ-035 areset high asynchronously forces: wr_bank = 0, rd_bank = 0, wr_cnt = 0, rd_cnt = 0, FSM = IDLE, bank_full = 2'b00, out_valid = 0, out_last = 0.
REQ-036 Reset mid-operation discards all partial and full banks; after reset, in_ready = 1 and all RAM strobes = 0.
REQ-037 Deassertion of areset SHALL be synchronous to inclk0 at the system level; the block adds no synchronizer.

Verification (DEPTH = 4, DW = 8)
REQ-038 Write 0x10..0x13 with out_ready = 0 -> bank_full = 01, wr_bank = B, in_ready = 1, no read strobes.
REQ-039 Write 8 words 0x20..0x27 with out_ready = 0 -> bank_full = 11, in_ready = 0; a 9th in_valid is not accepted and produces no we.
REQ-040 Continuous writes with out_ready = 1 -> out_data sequence 0x20..0x27 with out_last on 0x23 and 0x27, each word 1 cycle after its re, bank_full returning to 00.
REQ-041 Toggle out_ready 1/0 every cycle during READ -> read strobes only on ready cycles, data order intact, no duplicated or dropped word.
REQ-042 Bank A full and reader issuing its last read in the same cycle as the final write to bank B -> bank_full goes from 01 to 10 in one edge, with no write stall.
REQ-043 Assert areset after 2 words written and 1 word read -> next edge shows all outputs at reset values; a fresh 4-word burst reads back correctly from bank A.
